// File: rtl/serial_ha_adder.sv
// serial_ha_adder
// ---------------
// Bit-serial N-bit adder. Each RUN cycle, two half-adder cells and a carry
// flop form one full-adder slice. The slice walks the captured operands
// LSB-first over WIDTH cycles and builds the result in a right-shifting sum
// register.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..16), default 8
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   start  request, sampled only while idle
//   a, b   operands, captured on the accepted start edge
//   sub    (only with SERIAL_ADDER_SUB_EN) subtract select, captured with a/b
//   busy   high while an operation is running or completing
//   done   one-cycle pulse; sum/cout valid while high
//   sum    result, held until the next accepted start
//   cout   carry out of the MSB (in subtract mode, 1 = no borrow)
//
// Optional build macro:
//   SERIAL_ADDER_SUB_EN  adds the sub input and two's-complement subtraction.
module serial_ha_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Half-adder cell: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] opa_reg, opa_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  // Values loaded on an accepted start. Subtraction is a + ~b + 1, so B is
  // inverted at capture and the carry flop is preset to 1.
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub;
`else
  assign b_load     = b;
  assign carry_load = 1'b0;
`endif

  // One full-adder slice built from two half-adders.
  logic [1:0] ha1;
  logic [1:0] ha2;
  logic       slice_sum;
  logic       slice_carry;

  assign ha1         = half_add(opa_reg[0], opb_reg[0]);
  assign ha2         = half_add(ha1[0], carry_reg);
  assign slice_sum   = ha2[0];
  assign slice_carry = ha1[1] | ha2[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      opa_reg   <= '0;
      opb_reg   <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      opa_reg   <= opa_next;
      opb_reg   <= opb_next;
      sum_reg   <= sum_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    opa_next   = opa_reg;
    opb_next   = opb_reg;
    sum_next   = sum_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          opa_next   = a;
          opb_next   = b_load;
          carry_next = carry_load;
          cnt_next   = '0;
          sum_next   = '0;
          cout_next  = 1'b0;
          busy_next  = 1'b1;
        end
      end

      RUN: begin
        carry_next = slice_carry;
        // Result bits arrive LSB-first; after WIDTH shifts bit 0 lands in
        // position 0.
        sum_next   = {slice_sum, sum_reg[WIDTH-1:1]};
        opa_next   = {1'b0, opa_reg[WIDTH-1:1]};
        opb_next   = {1'b0, opb_reg[WIDTH-1:1]};
        if (cnt_reg == LAST_BIT) begin
          state_next = DONE;
          cout_next  = slice_carry;
          done_next  = 1'b1;
          // Park the counter at zero rather than letting it run past the
          // last bit position.
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
        done_next  = 1'b0;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        done_next  = 1'b0;
      end
    endcase
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_ha_adder.sv
// Testbench for serial_ha_adder (WIDTH=8). Table-driven operations plus
// hand-written sequences for ignored restart, mid-run reset and operand
// changes after capture. Expected {cout, sum} values go into a scoreboard
// queue when start is driven and are compared whenever done pulses.
module tb_serial_ha_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int errors = 0;

  logic [WIDTH:0] sb[$];

  typedef struct {
    string          name;
    logic [7:0]     va;
    logic [7:0]     vb;
    logic           vsub;
    logic [8:0]     exp;
  } vec_t;

  vec_t vecs[$];

  serial_ha_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation (sum=0x%0h)", sum);
      end else begin
        logic [WIDTH:0] e;
        e = sb.pop_front();
        check("done_sum", 32'(sum), 32'(e[WIDTH-1:0]));
        check("done_cout", 32'(cout), 32'(e[WIDTH]));
      end
    end
  end

  // Launch one operation and watch it for WIDTH+3 cycles. Optionally
  // scramble a/b after capture and/or pulse start again at cycle restart_k.
  task automatic run_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                        input logic vsub, input logic [8:0] exp,
                        input bit scramble, input int restart_k);
    int busy_cycles;
    int done_k;
    int done_hits;
    @(negedge clk);
    start = 1'b1;
    a     = va;
    b     = vb;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = vsub;
`endif
    sb.push_back(exp);
    busy_cycles = 0;
    done_k      = -1;
    done_hits   = 0;
    for (int k = 1; k <= WIDTH + 3; k++) begin
      @(negedge clk);
      if (k == 1) check({name, "_sum_cleared"}, 32'(sum), 32'd0);
      if (busy) busy_cycles++;
      if (done) begin
        done_hits++;
        if (done_k < 0) done_k = k;
      end
      start = (k == restart_k);
      if (k == restart_k) begin
        a = 8'hAA;
        b = 8'h55;
      end else if (scramble) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
    end
    check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(WIDTH + 1));
    check({name, "_done_latency"}, 32'(done_k), 32'(WIDTH + 1));
    check({name, "_done_pulses"}, 32'(done_hits), 32'd1);
    check({name, "_sum_hold"}, 32'(sum), 32'(exp[7:0]));
    check({name, "_cout_hold"}, 32'(cout), 32'(exp[8]));
    $display("op %s a=%02h b=%02h sub=%0b -> sum=%02h cout=%0b (want %02h/%0b)",
             name, va, vb, vsub, sum, cout, exp[7:0], exp[8]);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [8:0] rexp;

    vecs.push_back('{"add_35_4a", 8'h35, 8'h4A, 1'b0, 9'h07F});
    vecs.push_back('{"add_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100});
    vecs.push_back('{"add_ff_ff", 8'hFF, 8'hFF, 1'b0, 9'h1FE});
    vecs.push_back('{"add_00_00", 8'h00, 8'h00, 1'b0, 9'h000});
    vecs.push_back('{"add_80_80", 8'h80, 8'h80, 1'b0, 9'h100});
    vecs.push_back('{"add_5a_a5", 8'h5A, 8'hA5, 1'b0, 9'h0FF});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{"sub_10_01", 8'h10, 8'h01, 1'b1, 9'h10F});
    vecs.push_back('{"sub_01_02", 8'h01, 8'h02, 1'b1, 9'h0FF});
    vecs.push_back('{"nosub_35_35", 8'h35, 8'h35, 1'b0, 9'h06A});
`endif

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vsub, vecs[i].exp, 1'b0, 0);

    // Random additions against a simple arithmetic model.
    for (int i = 0; i < 4; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb};
      run_op("add_random", ra, rb, 1'b0, rexp, 1'b0, 0);
    end

    // Second start during RUN must be ignored.
    run_op("restart_ignored", 8'h10, 8'h20, 1'b0, 9'h030, 1'b0, 3);

    // Operands changing after capture must not matter.
    run_op("scramble_81_81", 8'h81, 8'h81, 1'b0, 9'h102, 1'b1, 0);

    // Reset in the middle of RUN aborts with no done.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h0F;
    b     = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * WIDTH) @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
    $display("op abort a=0f b=01 -> reset mid-run, busy=%0b sum=%02h", busy, sum);
    run_op("after_abort", 8'h02, 8'h03, 1'b0, 9'h005, 1'b0, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_ha_adder.md
Name: serial_ha_adder

Overview:
- Bit-serial N-bit adder built around the team's half-adder cell: two half-adders plus a carry flip-flop form a full-adder slice, iterated LSB-first over WIDTH cycles.
- Sits directly upstream of the TinyTapeout top-level pin mapping: it consumes operands from ui_in/uio_in and produces a result for uo_out.
- Trades area for latency, which suits small tiles.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; sum and cout are valid while it is high.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  carry out of the MSB; held with sum.

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous, active-low, and resets every flop immediately regardless of clk.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, bit counter=0, operand shift registers=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E: load a and b into shift registers; carry<=0; counter<=0; state->RUN. sum is cleared to 0 at E.
- IDLE, start=0: hold all state; outputs keep their last values.
- RUN, each edge: compute one slice from bit0 of each shift register and the carry flop.
  - h1 = a0 XOR b0; c1 = a0 AND b0.
  - s = h1 XOR carry; c2 = h1 AND carry.
  - carry <= c1 OR c2.
  - sum shifts right, with s inserted at bit WIDTH-1.
  - Operand registers shift right, filling with 0.
  - counter increments.
- RUN exit: on the edge where counter==WIDTH-1 (edge E+WIDTH), state->DONE and cout<=the new carry. After that edge, sum holds (a+b) mod 2^WIDTH.
- DONE: done=1 for exactly one cycle, between edges E+WIDTH and E+WIDTH+1. The next edge sets state->IDLE.
- Latency: done rises WIDTH cycles after the start-sampling edge. Minimum start-to-start spacing is WIDTH+2 cycles.
- start in RUN or DONE is ignored entirely: no queueing, and operands are not re-captured.
- a and b may change freely after capture without affecting the result.
- Reset asserted mid-RUN aborts the operation: all registers take their reset values, and no done is produced.
- done and busy are registered outputs, not combinational decodes of start.
- Counter width is clog2(WIDTH); it never wraps past WIDTH-1 in RUN.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), captured with the operands.
  - If sub=1: B is inverted on capture, carry initialises to 1, and sum = (a-b) mod 2^WIDTH. cout=1 means no borrow (a>=b unsigned).
  - If sub=0: identical to add mode.
- When undefined: port sub is absent; the carry always initialises to 0 and the block only adds.
- Timing and handshake are identical in both builds.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, start pulse -> done one cycle, 8 cycles after start edge; sum=0x7F, cout=0; busy high for 9 cycles.
- a=0xFF, b=0x01 -> sum=0x00, cout=1; then a=0xFF, b=0xFF -> sum=0xFE, cout=1.
- Start a=0x10, b=0x20; pulse start again with a=0xAA, b=0x55 at cycle 3 -> second start ignored; sum=0x30, cout=0; only one done pulse.
- Start a=0x0F, b=0x01; drop rst_n at cycle 4 -> busy, done, sum and cout are 0 immediately; a later start with a=0x02, b=0x03 gives sum=0x05.
- Change a and b every cycle after capture of a=0x81, b=0x81 -> sum=0x02, cout=1, unaffected by the changes.
- With SERIAL_ADDER_SUB_EN, sub=1: a=0x10, b=0x01 -> sum=0x0F, cout=1; a=0x01, b=0x02 -> sum=0xFF, cout=0.
